rf_scanner: RTL
===============

RF_SCANNER -- requirements
Module: rf_scanner

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter DATA_W, default 32, register data width.
REQ-003 SHALL have CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have START  input  1  one-cycle request to begin a scan.
REQ-006 SHALL have FIRST  input  ADDR_W  first register address, sampled when START is accepted.
REQ-007 SHALL have LAST  input  ADDR_W  last register address, sampled when START is accepted.
REQ-008 SHALL have RFRA  output  ADDR_W  read address driven to the register file read port.
REQ-009 SHALL have RFRD  input  DATA_W  combinational read data returned for RFRA.
REQ-010 SHALL have DOUT  output  DATA_W  captured register word.
REQ-011 SHALL have DIDX  output  ADDR_W  register address of the word on DOUT.
REQ-012 SHALL have DVAL  output  1  DOUT/DIDX valid.
REQ-013 SHALL have DRDY  input  1  downstream ready; a word transfers on a rising edge with DVAL=1 and DRDY=1.
REQ-014 SHALL have BUSY  output  1  high in every state except IDLE.
REQ-015 SHALL have DONE  output  1  one-cycle pulse after the final transfer.
REQ-016 SHALL have SUM  output  DATA_W  modulo-2^DATA_W sum of all words transferred in the current/last scan.

Function
REQ-017 SHALL implement states IDLE, READ, SEND, FINISH.
REQ-018 IDLE: START=1 -> latch FIRST into the address register, latch LAST, clear SUM, go to READ; otherwise stay.
REQ-019 READ: RFRA = address register; on the next edge capture RFRD into DOUT, address into DIDX, set DVAL=1, go to SEND.
REQ-020 SEND: DOUT, DIDX, DVAL SHALL hold stable until a transfer occurs.
REQ-021 SEND with transfer: SUM <= SUM + DOUT (wrap on overflow), DVAL <= 0; if DIDX == LAST go to FINISH, else increment address (31 wraps to 0) and go to READ.
REQ-022 FINISH: DONE=1 for exactly this one cycle, then go to IDLE.
REQ-023 LAST < FIRST SHALL scan with wrap-around (FIRST..31, 0..LAST); LAST == FIRST SHALL scan exactly one register.
REQ-024 Throughput: minimum 2 cycles per word; first DVAL=1 appears 2 edges after the edge accepting START.
REQ-025 START while BUSY=1 SHALL be ignored; START in the same cycle FINISH is active SHALL be ignored.
REQ-026 RFRA SHALL equal the address register in all states, so it is static while no read occurs.
REQ-027 SUM SHALL remain valid and unchanged from FINISH until the next accepted START.

Reset
REQ-028 RST=1 SHALL immediately force IDLE, DVAL=0, DONE=0, BUSY=0, DOUT=0, DIDX=0, RFRA=0, SUM=0, independent of CLK.
REQ-029 RST asserted mid-scan SHALL abort the scan with no DONE pulse and no further transfers; a new START after RST release SHALL start a fresh scan.

Verification
REQ-030 Full scan: RF model reg[k]=k*3, FIRST=0, LAST=31, DRDY=1 -> 32 transfers DIDX 0..31, DOUT 0..93, DONE at cycle 65 after START, SUM=1488.
REQ-031 Backpressure: FIRST=LAST=5, reg[5]=17, DRDY=0 for 4 cycles -> DVAL held, DOUT=17 and DIDX=5 stable; one transfer when DRDY=1; SUM=17.
REQ-032 Wrap range: FIRST=30, LAST=1 -> DIDX sequence 30,31,0,1 then DONE.
REQ-033 Overflow: reg[2]=0xFFFFFFFF, reg[3]=2, FIRST=2, LAST=3 -> SUM=0x00000001.
REQ-034 Mid-scan reset: RST pulsed during third SEND of a 0..31 scan -> all outputs 0 asynchronously, no DONE; subsequent START FIRST=7 LAST=7 yields single transfer DIDX=7.
REQ-035 START ignored: START pulsed while BUSY=1 -> scan sequence and SUM unchanged versus undisturbed run.

Source files
------------

// File: rtl/rf_scanner.sv
// Register-file scanner: walks FIRST..LAST (wrapping), offering each word downstream and summing transfers.
// States: IDLE wait for START | READ fetch word | SEND offer word | FINISH one-cycle done pulse.
module rf_scanner #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [ADDR_W-1:0] FIRST,
  input  logic [ADDR_W-1:0] LAST,
  output logic [ADDR_W-1:0] RFRA,
  input  logic [DATA_W-1:0] RFRD,
  output logic [DATA_W-1:0] DOUT,
  output logic [ADDR_W-1:0] DIDX,
  output logic              DVAL,
  input  logic              DRDY,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] SUM
);

  typedef enum logic [1:0] {IDLE, READ, SEND, FINISH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [ADDR_W-1:0] didx_q, didx_d;
  logic              dval_q, dval_d;
  logic [DATA_W-1:0] sum_q, sum_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      dout_q  <= '0;
      didx_q  <= '0;
      dval_q  <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      didx_q  <= didx_d;
      dval_q  <= dval_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    dout_d  = dout_q;
    didx_d  = didx_q;
    dval_d  = dval_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (START) begin
          addr_d  = FIRST;
          last_d  = LAST;
          sum_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        dout_d  = RFRD;
        didx_d  = addr_q;
        dval_d  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        // DVAL is high throughout SEND, so DRDY alone marks the transfer here.
        if (DRDY) begin
          sum_d  = sum_q + dout_q;
          dval_d = 1'b0;
          if (didx_q == last_q) begin
            state_d = FINISH;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign RFRA = addr_q;
  assign DOUT = dout_q;
  assign DIDX = didx_q;
  assign DVAL = dval_q;
  assign SUM  = sum_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = (state_q == FINISH);

endmodule
